uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
// Receive-side controller between the UART RX engine and the AXI-Lite register block. Accepts each
// received byte (rx_done pulse + data) into a show-ahead RX FIFO and serves register reads with a pop handshake.
// Tracks overrun and character-timeout (line idle while data is pending).
// Raises a level interrupt on FIFO threshold, timeout or overrun.
// PARAMETERS
// DEPTH          16    FIFO entries; power of two, >= 2
// TIMEOUT_TICKS  640   b_ticks without push/pop before timeout fires (4 chars x 10 bits x 16)
// CW (local)     $clog2(DEPTH)+1   width of count/threshold fields
// PORTS
// clk           in   1   system clock
// a_resetn      in   1   asynchronous active-low reset
// b_tick        in   1   16x-oversample baud tick, one clk wide
// rx_en         in   1   receive enable; bytes arriving while low are discarded
// rx_done       in   1   one-cycle pulse from RX engine: rx_data valid
// rx_data       in   8   received byte
// rd_en         in   1   pop request from register block (one pulse per byte)
// flush         in   1   synchronous FIFO clear
// ovr_clr       in   1   clears sticky overrun
// thresh        in   CW  interrupt level; 0 disables level interrupt
// rd_data       out  8   FIFO head byte (show-ahead), 8'h00 when empty
// rd_valid      out  1   FIFO not empty
// fifo_count    out  CW  entries held, 0..DEPTH
// overrun       out  1   sticky: byte lost because FIFO full
// timeout_flag  out  1   character timeout pending
// irq           out  1   registered interrupt
// BEHAVIOUR
// - Reset: FIFO empty, pointers 0, rd_valid=0, rd_data=0, fifo_count=0, overrun=0, timeout_flag=0, irq=0,
//   timer state T_EMPTY, timer count 0. Reset mid-frame discards all stored data.
// - Push = rx_done & rx_en & (!full | pop). Pop = rd_en & rd_valid. Pointers are CW-1 bits, wrap mod DEPTH.
// - Latency: push at cycle N -> fifo_count/rd_valid updated at N+1; rd_data shows new head at N+1.
// - Simultaneous push+pop: count unchanged; when full, the pop frees a slot and the push is accepted (no overrun).
// - rx_done & rx_en & full & !pop: byte dropped, overrun <= 1 at N+1; ovr_clr clears it, set wins if same cycle.
// - rx_done while rx_en=0: byte dropped silently, no overrun.
// - rd_en on empty FIFO: ignored, no pointer move, no error.
// - flush: pointers/count to 0, timeout_flag<=0, timer to T_EMPTY next cycle; overrun unaffected;
//   flush wins over push/pop in the same cycle.
// - Timeout FSM (timer counts b_ticks, width $clog2(TIMEOUT_TICKS+1)):
//   T_EMPTY : fifo empty; timer=0; -> T_COUNT when a push occurs.
//   T_COUNT : timer += 1 per b_tick; push or pop resets timer to 0 (stays T_COUNT if still non-empty);
//             FIFO becomes empty -> T_EMPTY; timer reaches TIMEOUT_TICKS -> T_EXPIRED, timeout_flag<=1.
//   T_EXPIRED : timeout_flag held; pop -> T_COUNT (or T_EMPTY if now empty), flag<=0, timer=0;
//             push -> T_COUNT, flag<=0, timer=0; flush -> T_EMPTY.
// - irq (registered, 1 cycle after cause) = ((thresh!=0) & (fifo_count>=thresh)) | timeout_flag | overrun.
// - thresh > DEPTH: level term never true.
// TESTING
// 1. Reset, push 3 bytes 8'hA1,8'hB2,8'hC3 -> fifo_count=3, rd_data=A1; 3 pops return A1,B2,C3, rd_valid=0.
// 2. Fill 16 bytes 0x00..0x0F, push 0x55 -> dropped, overrun=1, irq=1, count=16; ovr_clr -> overrun=0.
//    Full FIFO, push 0x77 with rd_en same cycle -> count stays 16, no overrun, tail=0x77.
// 3. thresh=4: push 3 -> irq=0; 4th push -> irq=1 one cycle after count=4; pop one -> irq=0.
// 4. Push 1 byte, idle 640 b_ticks -> timeout_flag=1, irq=1 on tick 640; 639 ticks then pop -> no timeout.
// 5. rx_en=0 with 2 rx_done pulses -> count 0, overrun 0; flush with count=5 and pending push -> count 0 next cycle.
// 6. Assert a_resetn low with count=7 and timeout_flag=1 -> all outputs 0 immediately, async.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: show-ahead RX FIFO between the RX engine and the register block,
// with sticky overrun, character-timeout tracking and a registered level interrupt.
module uart_rx_ctrl #(
    parameter int unsigned  DEPTH         = 16,
    parameter int unsigned  TIMEOUT_TICKS = 640,
    localparam int unsigned CW            = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          a_resetn,
    input  logic          b_tick,
    input  logic          rx_en,
    input  logic          rx_done,
    input  logic [7:0]    rx_data,
    input  logic          rd_en,
    input  logic          flush,
    input  logic          ovr_clr,
    input  logic [CW-1:0] thresh,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [CW-1:0] fifo_count,
    output logic          overrun,
    output logic          timeout_flag,
    output logic          irq
);

    localparam int unsigned PW = CW - 1;
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {
        T_EMPTY   = 2'd0,
        T_COUNT   = 2'd1,
        T_EXPIRED = 2'd2
    } tstate_t;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_rd_data;
    logic          r_rd_valid;
    logic          r_overrun;
    logic          r_to_flag;
    logic          r_irq;
    tstate_t       r_state;
    logic [TW-1:0] r_timer;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_wr_en;
    logic          w_ovr_set;
    logic [PW-1:0] w_wr_ptr_nxt;
    logic [PW-1:0] w_rd_ptr_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [7:0]    w_rd_data_nxt;
    logic          w_overrun_nxt;
    logic          w_irq_nxt;
    tstate_t       w_state_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic          w_to_flag_nxt;

    // FIFO pointer/count update; flush overrides any push or pop in the same cycle
    always_comb begin
        w_full        = (r_count == CW'(DEPTH));
        w_pop         = rd_en & r_rd_valid;
        w_push        = rx_done & rx_en & (~w_full | w_pop);
        w_ovr_set     = rx_done & rx_en & w_full & ~w_pop;
        w_wr_en       = w_push & ~flush;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_rd_ptr_nxt  = r_rd_ptr;
        w_count_nxt   = r_count;
        w_rd_data_nxt = 8'h00;

        if (flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                w_count_nxt = r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                w_count_nxt = r_count - CW'(1);
            end
        end

        // Next head is the byte being written this cycle when it lands in the new read slot
        if (w_count_nxt == '0) begin
            w_rd_data_nxt = 8'h00;
        end else if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
            w_rd_data_nxt = rx_data;
        end else begin
            w_rd_data_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    always_comb begin
        w_overrun_nxt = r_overrun;
        if (w_ovr_set) begin
            w_overrun_nxt = 1'b1;
        end else if (ovr_clr) begin
            w_overrun_nxt = 1'b0;
        end
        w_irq_nxt = ((thresh != '0) && (r_count >= thresh)) | r_to_flag | r_overrun;
    end

    // Character-timeout FSM: next state, timer and flag
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_to_flag_nxt = r_to_flag;

        if (flush) begin
            w_state_nxt   = T_EMPTY;
            w_timer_nxt   = '0;
            w_to_flag_nxt = 1'b0;
        end else begin
            case (r_state)
                T_EMPTY: begin
                    w_timer_nxt   = '0;
                    w_to_flag_nxt = 1'b0;
                    if (w_push) begin
                        w_state_nxt = T_COUNT;
                    end
                end
                T_COUNT: begin
                    if (w_count_nxt == '0) begin
                        w_state_nxt = T_EMPTY;
                        w_timer_nxt = '0;
                    end else if (w_push || w_pop) begin
                        w_timer_nxt = '0;
                    end else if (b_tick) begin
                        w_timer_nxt = r_timer + TW'(1);
                        if (r_timer + TW'(1) == TW'(TIMEOUT_TICKS)) begin
                            w_state_nxt   = T_EXPIRED;
                            w_to_flag_nxt = 1'b1;
                        end
                    end
                end
                T_EXPIRED: begin
                    if (w_push || w_pop) begin
                        w_state_nxt   = (w_count_nxt == '0) ? T_EMPTY : T_COUNT;
                        w_timer_nxt   = '0;
                        w_to_flag_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt   = T_EMPTY;
                    w_timer_nxt   = '0;
                    w_to_flag_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge a_resetn) begin
        if (!a_resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= (w_count_nxt != '0);
            r_overrun  <= w_overrun_nxt;
            r_irq      <= w_irq_nxt;
        end
    end

    always_ff @(posedge clk or negedge a_resetn) begin
        if (!a_resetn) begin
            r_state   <= T_EMPTY;
            r_timer   <= '0;
            r_to_flag <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_to_flag <= w_to_flag_nxt;
        end
    end

    // Storage array needs no reset: contents are only visible once written
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign fifo_count   = r_count;
    assign overrun      = r_overrun;
    assign timeout_flag = r_to_flag;
    assign irq          = r_irq;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 640;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;

    logic          clk;
    logic          a_resetn;
    logic          b_tick;
    logic          rx_en;
    logic          rx_done;
    logic [7:0]    rx_data;
    logic          rd_en;
    logic          flush;
    logic          ovr_clr;
    logic [CW-1:0] thresh;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [CW-1:0] fifo_count;
    logic          overrun;
    logic          timeout_flag;
    logic          irq;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] m_q[$];
    bit         m_ovr;
    bit         m_flag;
    bit         m_irq;
    int         m_idle;

    uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT_TICKS(TIMEOUT)) dut (
        .clk(clk), .a_resetn(a_resetn), .b_tick(b_tick), .rx_en(rx_en),
        .rx_done(rx_done), .rx_data(rx_data), .rd_en(rd_en), .flush(flush),
        .ovr_clr(ovr_clr), .thresh(thresh), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_count(fifo_count), .overrun(overrun), .timeout_flag(timeout_flag), .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_q.delete();
        m_ovr  = 1'b0;
        m_flag = 1'b0;
        m_irq  = 1'b0;
        m_idle = 0;
    endtask

    // One clock of reference behaviour, evaluated from the inputs present at the edge
    task automatic model_step();
        int n;
        bit pop, push, full, lost;
        n    = m_q.size();
        pop  = rd_en && (n > 0);
        full = (n == DEPTH);
        push = rx_done && rx_en && (!full || pop);
        lost = rx_done && rx_en && full && !pop;
        m_irq = ((thresh != 0) && (n >= int'(thresh))) || m_flag || m_ovr;
        if (lost) m_ovr = 1'b1;
        else if (ovr_clr) m_ovr = 1'b0;
        if (flush) begin
            m_q.delete();
            m_idle = 0;
            m_flag = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(rx_data);
            if (push || pop) begin
                m_idle = 0;
                m_flag = 1'b0;
            end else if ((m_q.size() > 0) && !m_flag && b_tick) begin
                m_idle++;
                if (m_idle == TIMEOUT) m_flag = 1'b1;
            end
            if (m_q.size() == 0) begin
                m_idle = 0;
                m_flag = 1'b0;
            end
        end
    endtask

    function automatic logic [7:0] m_head();
        return (m_q.size() > 0) ? m_q[0] : 8'h00;
    endfunction

    // Advance one clock, update the model, then settle and release one-shot inputs
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        rx_done = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        ovr_clr = 1'b0;
        b_tick  = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        rx_done = 1'b1;
        rx_data = d;
        cyc();
    endtask

    task automatic test_reset();
        a_resetn = 1'b1;
        #3 a_resetn = 1'b0;
        #1;
        model_reset();
        n_total++; if (fifo_count !== 0) $display("FAIL reset_count: got %0d want 0", fifo_count); else n_pass++;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rd_valid); else n_pass++;
        n_total++; if (rd_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rd_data); else n_pass++;
        n_total++; if ({overrun, timeout_flag, irq} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {overrun, timeout_flag, irq}); else n_pass++;
        #8 a_resetn = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3;
        push_byte(8'hA1);
        n_total++; if (rd_data !== 8'hA1 || fifo_count !== 1) $display("FAIL basic_first: got %h/%0d want a1/1", rd_data, fifo_count); else n_pass++;
        push_byte(8'hB2);
        push_byte(8'hC3);
        n_total++; if (fifo_count !== 3) $display("FAIL basic_count: got %0d want 3", fifo_count); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (rd_data !== exp_b[i]) $display("FAIL basic_pop%0d: got %h want %h", i, rd_data, exp_b[i]); else n_pass++;
            rd_en = 1'b1;
            cyc();
        end
        n_total++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) $display("FAIL basic_empty: got %b/%h want 0/00", rd_valid, rd_data); else n_pass++;
        rd_en = 1'b1;
        cyc();
        n_total++; if (fifo_count !== 0 || overrun !== 1'b0) $display("FAIL basic_pop_empty: got %0d/%b want 0/0", fifo_count, overrun); else n_pass++;
    endtask

    task automatic test_overrun();
        logic [7:0] last;
        last = 8'h00;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        n_total++; if (fifo_count !== 16 || overrun !== 1'b0) $display("FAIL ovr_full: got %0d/%b want 16/0", fifo_count, overrun); else n_pass++;
        push_byte(8'h55);
        n_total++; if (overrun !== 1'b1 || fifo_count !== 16) $display("FAIL ovr_set: got %b/%0d want 1/16", overrun, fifo_count); else n_pass++;
        cyc();
        n_total++; if (irq !== 1'b1) $display("FAIL ovr_irq: got %b want 1", irq); else n_pass++;
        ovr_clr = 1'b1;
        cyc();
        n_total++; if (overrun !== 1'b0) $display("FAIL ovr_clr: got %b want 0", overrun); else n_pass++;
        rx_done = 1'b1; rx_data = 8'h77; rd_en = 1'b1;
        cyc();
        n_total++; if (fifo_count !== 16 || overrun !== 1'b0 || rd_data !== 8'h01) $display("FAIL ovr_pushpop: got %0d/%b/%h want 16/0/01", fifo_count, overrun, rd_data); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_total++; if (rd_data !== m_head()) $display("FAIL ovr_drain%0d: got %h want %h", i, rd_data, m_head()); else n_pass++;
            last = rd_data;
            rd_en = 1'b1;
            cyc();
        end
        n_total++; if (last !== 8'h77 || rd_valid !== 1'b0) $display("FAIL ovr_tail: got %h/%b want 77/0", last, rd_valid); else n_pass++;
    endtask

    task automatic test_thresh();
        thresh = CW'(4);
        for (int i = 0; i < 3; i++) push_byte(8'(8'h30 + i));
        cyc();
        n_total++; if (irq !== 1'b0) $display("FAIL thr_below: got %b want 0", irq); else n_pass++;
        push_byte(8'h33);
        n_total++; if (fifo_count !== 4 || irq !== 1'b0) $display("FAIL thr_lat: got %0d/%b want 4/0", fifo_count, irq); else n_pass++;
        cyc();
        n_total++; if (irq !== 1'b1) $display("FAIL thr_hit: got %b want 1", irq); else n_pass++;
        rd_en = 1'b1;
        cyc();
        cyc();
        n_total++; if (irq !== 1'b0 || fifo_count !== 3) $display("FAIL thr_drop: got %b/%0d want 0/3", irq, fifo_count); else n_pass++;
        thresh = CW'(DEPTH + 1);
        for (int i = 0; i < 13; i++) push_byte(8'(i));
        cyc();
        n_total++; if (irq !== 1'b0 || fifo_count !== 16) $display("FAIL thr_above_depth: got %b/%0d want 0/16", irq, fifo_count); else n_pass++;
        flush = 1'b1;
        cyc();
        thresh = '0;
        cyc();
    endtask

    task automatic test_timeout();
        push_byte(8'h5A);
        for (int i = 0; i < TIMEOUT - 1; i++) begin b_tick = 1'b1; cyc(); end
        n_total++; if (timeout_flag !== 1'b0) $display("FAIL to_early: got %b want 0", timeout_flag); else n_pass++;
        b_tick = 1'b1;
        cyc();
        n_total++; if (timeout_flag !== 1'b1) $display("FAIL to_fire: got %b want 1", timeout_flag); else n_pass++;
        cyc();
        n_total++; if (irq !== 1'b1) $display("FAIL to_irq: got %b want 1", irq); else n_pass++;
        rd_en = 1'b1;
        cyc();
        n_total++; if (timeout_flag !== 1'b0 || rd_valid !== 1'b0) $display("FAIL to_popclr: got %b/%b want 0/0", timeout_flag, rd_valid); else n_pass++;
        push_byte(8'hA5);
        for (int i = 0; i < TIMEOUT - 1; i++) begin b_tick = 1'b1; cyc(); end
        rd_en = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin b_tick = 1'b1; cyc(); end
        n_total++; if (timeout_flag !== 1'b0 || irq !== 1'b0) $display("FAIL to_nofire: got %b/%b want 0/0", timeout_flag, irq); else n_pass++;
    endtask

    task automatic test_rxen_flush();
        rx_en = 1'b0;
        push_byte(8'h11);
        push_byte(8'h22);
        n_total++; if (fifo_count !== 0 || overrun !== 1'b0) $display("FAIL rxen_drop: got %0d/%b want 0/0", fifo_count, overrun); else n_pass++;
        rx_en = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(8'(8'h40 + i));
        n_total++; if (fifo_count !== 5) $display("FAIL flush_pre: got %0d want 5", fifo_count); else n_pass++;
        flush = 1'b1; rx_done = 1'b1; rx_data = 8'h99;
        cyc();
        n_total++; if (fifo_count !== 0 || rd_valid !== 1'b0 || rd_data !== 8'h00) $display("FAIL flush_clr: got %0d/%b/%h want 0/0/00", fifo_count, rd_valid, rd_data); else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) thresh = CW'($urandom_range(0, DEPTH + 2));
            rx_en   = ($urandom_range(0, 9) != 0);
            rx_done = ($urandom_range(0, 9) < 5);
            rx_data = 8'($urandom);
            rd_en   = ($urandom_range(0, 9) < 4);
            flush   = ($urandom_range(0, 99) < 2);
            ovr_clr = ($urandom_range(0, 99) < 5);
            b_tick  = ($urandom_range(0, 1) == 1);
            cyc();
            n_total++; if (fifo_count !== CW'(m_q.size())) $display("FAIL rnd_count c%0d: got %0d want %0d", c, fifo_count, m_q.size()); else n_pass++;
            n_total++; if (rd_data !== m_head() || rd_valid !== (m_q.size() > 0)) $display("FAIL rnd_head c%0d: got %h/%b want %h/%b", c, rd_data, rd_valid, m_head(), m_q.size() > 0); else n_pass++;
            n_total++; if ({overrun, timeout_flag, irq} !== {m_ovr, m_flag, m_irq}) $display("FAIL rnd_flags c%0d: got %b want %b", c, {overrun, timeout_flag, irq}, {m_ovr, m_flag, m_irq}); else n_pass++;
        end
        rx_en  = 1'b1;
        thresh = '0;
        flush  = 1'b1;
        cyc();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) push_byte(8'(8'h70 + i));
        for (int i = 0; i < TIMEOUT; i++) begin b_tick = 1'b1; cyc(); end
        n_total++; if (fifo_count !== 7 || timeout_flag !== 1'b1) $display("FAIL ar_pre: got %0d/%b want 7/1", fifo_count, timeout_flag); else n_pass++;
        #2 a_resetn = 1'b0;
        #1;
        model_reset();
        n_total++; if (fifo_count !== 0 || rd_valid !== 1'b0 || rd_data !== 8'h00) $display("FAIL ar_fifo: got %0d/%b/%h want 0/0/00", fifo_count, rd_valid, rd_data); else n_pass++;
        n_total++; if ({overrun, timeout_flag, irq} !== 3'b000) $display("FAIL ar_flags: got %b want 000", {overrun, timeout_flag, irq}); else n_pass++;
        #3 a_resetn = 1'b1;
        cyc();
        push_byte(8'hE1);
        n_total++; if (fifo_count !== 1 || rd_data !== 8'hE1) $display("FAIL ar_after: got %0d/%h want 1/e1", fifo_count, rd_data); else n_pass++;
    endtask

    initial begin
        a_resetn = 1'b1;
        b_tick   = 1'b0;
        rx_en    = 1'b1;
        rx_done  = 1'b0;
        rx_data  = 8'h00;
        rd_en    = 1'b0;
        flush    = 1'b0;
        ovr_clr  = 1'b0;
        thresh   = '0;
        model_reset();
        test_reset();
        test_basic();
        test_overrun();
        test_thresh();
        test_timeout();
        test_rxen_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
